// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: PRF/free-list geometry, pointer types and
// small mask helpers used by the free list, the rename stage and the ROB.
package rename_pkg;

  localparam int PRF_WIDTH  = 6;
  localparam int ARF_NUM    = 32;
  localparam int FL_DEPTH   = 32;
  localparam int DECODE_NUM = 4;

  // Free-list index width and pointer width (one extra wrap bit)
  localparam int FL_IDX_W = $clog2(FL_DEPTH);
  localparam int PTR_W    = FL_IDX_W + 1;

  typedef logic [PTR_W-1:0]     ptr_t;
  typedef logic [FL_IDX_W-1:0]  fl_idx_t;
  typedef logic [PRF_WIDTH-1:0] prd_t;

  // Number of set bits in a 4-lane valid mask (0..4)
  function automatic logic [2:0] popcount4(input logic [3:0] mask);
    return 3'(mask[0]) + 3'(mask[1]) + 3'(mask[2]) + 3'(mask[3]);
  endfunction

  // Number of set bits strictly below the given lane, i.e. the compacted
  // slot that lane occupies when valid lanes are packed in lane order
  function automatic logic [1:0] lane_prefix(input logic [3:0] mask, input int lane);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < lane && mask[i]) begin
        cnt = cnt + 3'd1;
      end
    end
    return cnt[1:0];
  endfunction

endpackage

// File: rtl/lane_compact.sv
// Turns a 4-lane valid mask into per-lane packed offsets and a total count,
// so each valid lane knows which consecutive free-list slot it owns.
module lane_compact
  import rename_pkg::*;
(
  input  logic [3:0]      mask,
  output logic [3:0][1:0] offset,
  output logic [2:0]      count
);

  // Prefix offsets and population count of the mask
  always_comb begin
    count = popcount4(mask);
    for (int i = 0; i < 4; i++) begin
      offset[i] = lane_prefix(mask, i);
    end
  end

endmodule

// File: rtl/prf_freelist_ctrl.sv
// Physical-register free list. Rename takes up to four tags per cycle as an
// all-or-nothing group; commit returns old tags at the tail. A committed head
// pointer lets a flush hand every speculative allocation back in one cycle.
module prf_freelist_ctrl
  import rename_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           alloc_req,
  output logic                 alloc_gnt,
  output logic [PRF_WIDTH-1:0] alloc_prd0,
  output logic [PRF_WIDTH-1:0] alloc_prd1,
  output logic [PRF_WIDTH-1:0] alloc_prd2,
  output logic [PRF_WIDTH-1:0] alloc_prd3,
  input  logic [3:0]           rel_v,
  input  logic [PRF_WIDTH-1:0] rel_prd0,
  input  logic [PRF_WIDTH-1:0] rel_prd1,
  input  logic [PRF_WIDTH-1:0] rel_prd2,
  input  logic [PRF_WIDTH-1:0] rel_prd3,
  input  logic [3:0]           cmt_v,
  input  logic                 flush,
  output logic [5:0]           free_cnt,
  output logic                 err_ovf
);

  prd_t fl [FL_DEPTH];
  ptr_t head;
  ptr_t cmt_head;
  ptr_t tail;

  logic [3:0][1:0] alloc_off;
  logic [2:0]      alloc_cnt;
  logic [3:0][1:0] rel_off;
  logic [2:0]      rel_cnt;
  logic [3:0][1:0] cmt_off;
  logic [2:0]      cmt_cnt;

  prd_t rel_prd [4];
  prd_t alloc_prd [4];
  logic rel_ovf;

  fl_idx_t head_idx;
  fl_idx_t tail_idx;

  lane_compact u_alloc_compact (
    .mask   (alloc_req),
    .offset (alloc_off),
    .count  (alloc_cnt)
  );

  lane_compact u_rel_compact (
    .mask   (rel_v),
    .offset (rel_off),
    .count  (rel_cnt)
  );

  lane_compact u_cmt_compact (
    .mask   (cmt_v),
    .offset (cmt_off),
    .count  (cmt_cnt)
  );

  assign rel_prd[0] = rel_prd0;
  assign rel_prd[1] = rel_prd1;
  assign rel_prd[2] = rel_prd2;
  assign rel_prd[3] = rel_prd3;

  assign alloc_prd0 = alloc_prd[0];
  assign alloc_prd1 = alloc_prd[1];
  assign alloc_prd2 = alloc_prd[2];
  assign alloc_prd3 = alloc_prd[3];

  assign head_idx = head[FL_IDX_W-1:0];
  assign tail_idx = tail[FL_IDX_W-1:0];

  // Occupancy straight from the registered pointers; the wrap bit makes a
  // full list (32) distinguishable from an empty one (0)
  assign free_cnt = tail - head;

  // A release that would push occupancy past the list depth is dropped
  assign rel_ovf = ({1'b0, free_cnt} + 7'(rel_cnt)) > 7'(FL_DEPTH);

  // Group grant and zero-latency tag lookup for the compacted request lanes
  always_comb begin
    fl_idx_t idx;
    idx       = '0;
    alloc_gnt = !flush && (alloc_cnt != 3'd0) && ({3'b000, alloc_cnt} <= free_cnt);
    for (int i = 0; i < 4; i++) begin
      idx          = head_idx + fl_idx_t'(alloc_off[i]);
      alloc_prd[i] = alloc_req[i] ? fl[idx] : '0;
    end
  end

  // Free-list storage: identity-mapped tags above the ARF at reset, then
  // released tags appended at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl[i] <= prd_t'(ARF_NUM + i);
      end
    end else if (!rel_ovf) begin
      for (int i = 0; i < 4; i++) begin
        if (rel_v[i]) begin
          fl[tail_idx + fl_idx_t'(rel_off[i])] <= rel_prd[i];
        end
      end
    end
  end

  // Pointer update; flush rewinds head to the committed point including any
  // commits happening in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      cmt_head <= '0;
      tail     <= ptr_t'(FL_DEPTH);
    end else begin
      cmt_head <= cmt_head + ptr_t'(cmt_cnt);
      if (flush) begin
        head <= cmt_head + ptr_t'(cmt_cnt);
      end else if (alloc_gnt) begin
        head <= head + ptr_t'(alloc_cnt);
      end
      if (!rel_ovf) begin
        tail <= tail + ptr_t'(rel_cnt);
      end
    end
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
    end else if (rel_ovf) begin
      err_ovf <= 1'b1;
    end
  end

endmodule
